// File: rtl/activation_skew_feeder.sv
// ---------------------------------------------------------------------------
// activation_skew_feeder
//
// Buffers up to DEPTH activation vectors (SYS_ROWS elements of A_BITWIDTH
// bits each) and, on start, streams them into the rows of a weight-stationary
// systolic array with a diagonal skew: row r lags row 0 by r cycles.
// The array throttles the stream with i_sa_ready.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_wr_valid   write request from the input loader
//   o_wr_ready   write accepted when i_wr_valid && o_wr_ready (IDLE, not full)
//   i_wr_data    vector, element r in bits [r*A_BITWIDTH +: A_BITWIDTH]
//   i_start      begin streaming the buffered vectors
//   i_sa_ready   array consumes the current slice at this edge
//   o_a_out      skewed row data, same packing as i_wr_data
//   o_a_valid    per-row valid
//   o_busy       high while streaming or draining
//   o_done       one-cycle pulse when the stream completes
// ---------------------------------------------------------------------------
module activation_skew_feeder #(
    parameter int A_BITWIDTH = 8,
    parameter int SYS_ROWS   = 4,
    parameter int DEPTH      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_wr_valid,
    output logic                             o_wr_ready,
    input  logic [SYS_ROWS*A_BITWIDTH-1:0]   i_wr_data,
    input  logic                             i_start,
    input  logic                             i_sa_ready,
    output logic [SYS_ROWS*A_BITWIDTH-1:0]   o_a_out,
    output logic [SYS_ROWS-1:0]              o_a_valid,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Slice counter must reach DEPTH+SYS_ROWS-1 (one past the last slice).
    localparam int SW = $clog2(DEPTH + SYS_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_c;
    logic            r_busy;
    logic            r_done;

    logic            w_wr_fire;
    logic            w_load;
    logic            w_clear;
    logic [SW-1:0]   w_last;

    assign o_wr_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign w_wr_fire  = i_wr_valid && o_wr_ready;
    assign w_load     = (r_state == S_STREAM) && i_sa_ready;
    assign w_clear    = (r_state == S_DRAIN) && i_sa_ready;
    // Index of the final slice: N + SYS_ROWS - 2 (count holds N while streaming).
    assign w_last     = SW'(r_count) + SW'(SYS_ROWS - 2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_fire) begin
                        r_count <= r_count + 1'b1;
                    end
                    // A write in the start cycle is part of this stream.
                    if (i_start && ((r_count != '0) || w_wr_fire)) begin
                        r_state <= S_STREAM;
                        r_c     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (i_sa_ready) begin
                        r_c <= r_c + 1'b1;
                        if (r_c == w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_sa_ready) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_c     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

    // One storage column per row: each row reads its own address (c - r),
    // so every column needs only a single read port.
    generate
        for (genvar gi = 0; gi < SYS_ROWS; gi++) begin : g_row
            logic [A_BITWIDTH-1:0] r_mem [DEPTH];
            logic [A_BITWIDTH-1:0] r_row_data;
            logic                  r_row_valid;
            logic [SW-1:0]         w_rel;
            logic                  w_hit;

            assign w_rel = r_c - SW'(gi);
            assign w_hit = (r_c >= SW'(gi)) && (w_rel < SW'(r_count));

            always_ff @(posedge i_clk) begin
                if (w_wr_fire) begin
                    r_mem[r_count[AW-1:0]] <= i_wr_data[gi*A_BITWIDTH +: A_BITWIDTH];
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_row_data  <= '0;
                    r_row_valid <= 1'b0;
                end else if (w_load) begin
                    r_row_data  <= w_hit ? r_mem[w_rel[AW-1:0]] : '0;
                    r_row_valid <= w_hit;
                end else if (w_clear) begin
                    r_row_data  <= '0;
                    r_row_valid <= 1'b0;
                end
            end

            assign o_a_out[gi*A_BITWIDTH +: A_BITWIDTH] = r_row_data;
            assign o_a_valid[gi]                        = r_row_valid;
        end
    endgenerate

endmodule

// File: tb/tb_activation_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_activation_skew_feeder
//
// Directed bench for activation_skew_feeder (A_BITWIDTH=8, SYS_ROWS=4,
// DEPTH=16). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so "cycle T+k" is observed k edges after the
// edge T that sampled start.
// ---------------------------------------------------------------------------
module tb_activation_skew_feeder;

    localparam int A  = 8;
    localparam int R  = 4;
    localparam int D  = 16;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_wr_valid;
    logic            o_wr_ready;
    logic [R*A-1:0]  i_wr_data;
    logic            i_start;
    logic            i_sa_ready;
    logic [R*A-1:0]  o_a_out;
    logic [R-1:0]    o_a_valid;
    logic            o_busy;
    logic            o_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]     tb_vec [D][R];
    logic [R*A-1:0] trace_out  [64];
    logic [R-1:0]   trace_v    [64];
    logic           trace_done [64];

    activation_skew_feeder #(
        .A_BITWIDTH (A),
        .SYS_ROWS   (R),
        .DEPTH      (D)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_data  (i_wr_data),
        .i_start    (i_start),
        .i_sa_ready (i_sa_ready),
        .o_a_out    (o_a_out),
        .o_a_valid  (o_a_valid),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Write one vector; remembers it in the bench copy at slot idx.
    task automatic write_vec(input int idx, input logic [R*A-1:0] d);
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        if (idx < D) begin
            for (int r = 0; r < R; r++) tb_vec[idx][r] = d[r*A +: A];
        end
        step();
        i_wr_valid = 1'b0;
    endtask

    // Apply start for one edge (optionally with a write of slot idx).
    task automatic pulse_start(input logic with_wr, input int idx, input logic [R*A-1:0] d);
        i_start = 1'b1;
        if (with_wr) begin
            i_wr_valid = 1'b1;
            i_wr_data  = d;
            for (int r = 0; r < R; r++) tb_vec[idx][r] = d[r*A +: A];
        end
        step();
        i_start    = 1'b0;
        i_wr_valid = 1'b0;
    endtask

    // Called in cycle T+1. Checks every cycle up to and including the done
    // cycle, and stays in the done cycle on return. sa_ready is low for
    // cycles T+st .. T+st+sl-1. Expected values follow the timing rules:
    // row r valid in effective cycles 2+r .. 1+r+n carrying vector (e-2-r).
    task automatic check_stream(input int n, input int st, input int sl, input string name);
        int stalls = 0;
        int e;
        int last_x = n + R + 1 + sl;
        logic [R*A-1:0] exp_out;
        logic [R-1:0]   exp_v;
        logic           exp_busy, exp_done;
        for (int x = 1; x <= last_x; x++) begin
            e = x - stalls;
            i_sa_ready = !((sl > 0) && (x >= st) && (x < st + sl));
            exp_out = '0;
            exp_v   = '0;
            for (int r = 0; r < R; r++) begin
                if (e >= 2 + r && e <= 1 + r + n) begin
                    exp_v[r]        = 1'b1;
                    exp_out[r*A +: A] = tb_vec[e-2-r][r];
                end
            end
            exp_busy = (e >= 1) && (e <= n + R);
            exp_done = (e == n + R + 1);
            if (x < 64) begin
                trace_out[x]  = o_a_out;
                trace_v[x]    = o_a_valid;
                trace_done[x] = o_done;
            end
            tests_run++;
            if (o_a_out !== exp_out) begin
                tests_failed++;
                $display("FAIL %s a_out T+%0d: got %h expected %h", name, x, o_a_out, exp_out);
            end
            tests_run++;
            if (o_a_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL %s a_valid T+%0d: got %b expected %b", name, x, o_a_valid, exp_v);
            end
            tests_run++;
            if (o_busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy T+%0d: got %b expected %b", name, x, o_busy, exp_busy);
            end
            tests_run++;
            if (o_done !== exp_done) begin
                tests_failed++;
                $display("FAIL %s done T+%0d: got %b expected %b", name, x, o_done, exp_done);
            end
            if (!i_sa_ready) stalls++;
            if (x != last_x) step();
        end
        i_sa_ready = 1'b1;
        $display("[TB] %s: streamed N=%0d with %0d stall cycles", name, n, sl);
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if (o_a_out !== '0 || o_a_valid !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: got a_out=%h a_valid=%b busy=%b done=%b wr_ready=%b expected 0/0/0/0/1",
                     name, o_a_out, o_a_valid, o_busy, o_done, o_wr_ready);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_wr_valid = 1'($urandom);
            i_start    = 1'($urandom);
            i_sa_ready = 1'($urandom);
            i_wr_data  = $urandom;
            step();
            check_idle_outputs($sformatf("reset_hold_%0d", k));
        end
        i_wr_valid = 1'b0;
        i_start    = 1'b0;
        i_sa_ready = 1'b1;
        i_rst_n    = 1'b1;
        step();
        check_idle_outputs("reset_release");
        write_vec(0, 32'hA3A2A1A0);
        $display("[TB] test_reset: wrote one vector after reset release");
        pulse_start(1'b0, 0, '0);
        check_stream(1, 0, 0, "reset_first_load");
        step();
    endtask

    task automatic test_basic_skew();
        logic [R-1:0] exp_tbl [2:6];
        exp_tbl[2] = 4'b0001; exp_tbl[3] = 4'b0011; exp_tbl[4] = 4'b0110;
        exp_tbl[5] = 4'b1100; exp_tbl[6] = 4'b1000;
        write_vec(0, 32'h04030201);
        write_vec(1, 32'h14131211);
        pulse_start(1'b0, 0, '0);
        check_stream(2, 0, 0, "basic");
        for (int x = 2; x <= 6; x++) begin
            tests_run++;
            if (trace_v[x] !== exp_tbl[x]) begin
                tests_failed++;
                $display("FAIL basic_valid_table T+%0d: got %b expected %b", x, trace_v[x], exp_tbl[x]);
            end
        end
        tests_run++;
        if (trace_out[2][7:0] !== 8'h01 || trace_out[3][7:0] !== 8'h11) begin
            tests_failed++;
            $display("FAIL basic_row0: got %h,%h expected 01,11", trace_out[2][7:0], trace_out[3][7:0]);
        end
        tests_run++;
        if (trace_out[5][31:24] !== 8'h04 || trace_out[6][31:24] !== 8'h14) begin
            tests_failed++;
            $display("FAIL basic_row3: got %h,%h expected 04,14", trace_out[5][31:24], trace_out[6][31:24]);
        end
        tests_run++;
        if (trace_done[7] !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done_T7: got %b expected 1", trace_done[7]);
        end
        step();
    endtask

    task automatic test_full_buffer();
        logic [R*A-1:0] d;
        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < R; r++) d[r*A +: A] = 8'((i * 16) + r);
            tests_run++;
            if (o_wr_ready !== (i < 16)) begin
                tests_failed++;
                $display("FAIL full_wr_ready before write %0d: got %b expected %b", i, o_wr_ready, (i < 16));
            end
            write_vec(i, d);
        end
        tests_run++;
        if (o_wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_wr_ready after 17 writes: got %b expected 0", o_wr_ready);
        end
        pulse_start(1'b0, 0, '0);
        check_stream(16, 0, 0, "full_buffer");
        step();
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) write_vec(i, {8'(8'h50 + i), 8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i)});
        pulse_start(1'b0, 0, '0);
        check_stream(4, 4, 3, "back_pressure");
        step();
    endtask

    task automatic test_start_corner();
        pulse_start(1'b0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_a_valid !== '0) begin
                tests_failed++;
                $display("FAIL start_empty cycle %0d: got busy=%b done=%b valid=%b expected 0/0/0",
                         k, o_busy, o_done, o_a_valid);
            end
            step();
        end
        pulse_start(1'b1, 0, 32'hDDCCBBAA);
        check_stream(1, 0, 0, "start_with_write");
    endtask

    // Entered in the done cycle of the previous stream: write + start here.
    task automatic test_back_to_back();
        tests_run++;
        if (o_done !== 1'b1 || o_wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done_cycle: got done=%b wr_ready=%b expected 1/1", o_done, o_wr_ready);
        end
        pulse_start(1'b1, 0, 32'h78563412);
        check_stream(1, 0, 0, "back_to_back");
        step();
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 8; i++) write_vec(i, {8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i), 8'(8'hB0 + i)});
        pulse_start(1'b0, 0, '0);
        step(); step(); step();
        tests_run++;
        if (o_a_valid !== 4'b0111 || o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre T+4: got valid=%b busy=%b expected 0111/1", o_a_valid, o_busy);
        end
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst_immediate");
        step();
        check_idle_outputs("midrst_hold");
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_idle_outputs($sformatf("midrst_after_%0d", k));
        end
        write_vec(0, 32'h0F0E0D0C);
        pulse_start(1'b0, 0, '0);
        check_stream(1, 0, 0, "midrst_reload");
        step();
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_start    = 1'b0;
        i_sa_ready = 1'b1;
        test_reset();
        test_basic_skew();
        test_full_buffer();
        test_back_pressure();
        test_start_corner();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/activation_skew_feeder.md
# activation_skew_feeder

Upstream feeder for the weight-stationary systolic array. Buffers up to `DEPTH` activation vectors, each `SYS_ROWS` elements of `A_BITWIDTH` bits, written by the input loader. On `start` it streams the vectors into the array's row inputs with the diagonal skew the array requires: row r lags row 0 by r cycles. The array can back-pressure the stream through `sa_ready`.

## Interface
- `A_BITWIDTH`, default 8: activation element width.
- `SYS_ROWS`, default 4: systolic array rows, equal to the number of elements per vector.
- `DEPTH`, default 16: buffer capacity in vectors, equal to the input buffer depth.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_data`  in  SYS_ROWS*A_BITWIDTH  vector; element r is in bits [r*A_BITWIDTH +: A_BITWIDTH].
- `start`  in  1  begin streaming the buffered vectors.
- `sa_ready`  in  1  array accepts the current output slice.
- `a_out`  out  SYS_ROWS*A_BITWIDTH  skewed row data, same packing as `wr_data`.
- `a_valid`  out  SYS_ROWS  per-row valid.
- `busy`  out  1  high in STREAM and DRAIN.
- `done`  out  1  one-cycle pulse when the stream completes.

## Operation
- Storage: `DEPTH` x vector buffer, write pointer = `count` (width $clog2(DEPTH+1)). N = `count` at the moment `start` is accepted.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - `wr_ready` = (count < DEPTH).
  - An accepted write stores the vector at `count`, then `count`++.
  - `start` with count > 0, or with count == 0 and a write accepted in the same cycle, goes to STREAM with c = 0. That same-cycle write is included in N.
  - `start` with count == 0 and no write is ignored; no `done` pulse.
- STREAM:
  - `wr_ready` = 0; `start` is ignored.
  - At each edge with `sa_ready` = 1, the output registers load slice c, then c++.
  - Slice c, for each row r: if 0 ≤ c−r < N, then a_out[r] = buf[c−r][r] and a_valid[r] = 1; otherwise a_out[r] = 0 and a_valid[r] = 0.
  - After loading c = N+SYS_ROWS−2, go to DRAIN.
  - With `sa_ready` = 0, c and the output registers hold.
- DRAIN:
  - At the next edge with `sa_ready` = 1: clear `a_out` and `a_valid`, set `count` = 0, go to IDLE, and register `done` = 1 for exactly one cycle.
- Consumption rule: the slice on `a_out`/`a_valid` is consumed by the array at every edge where `sa_ready` = 1.
- Data passes unmodified; no arithmetic on elements.

## Timing
- Reset values (asserted asynchronously, released synchronously):
  - IDLE, count = 0, c = 0.
  - `a_out` = 0, `a_valid` = 0, `busy` = 0, `done` = 0.
  - `wr_ready` = 1.
- Latency, with `start` sampled at edge T and no stalls:
  - `busy` is high from cycle T+1.
  - Slice c is visible in cycle T+2+c.
  - Row r is valid during cycles T+2+r … T+1+r+N.
  - Total streamed slices: N+SYS_ROWS−1.
  - DRAIN occupies cycle T+N+SYS_ROWS.
  - `done` = 1 and `busy` = 0 in cycle T+N+SYS_ROWS+1.
- Each `sa_ready` = 0 cycle in STREAM or DRAIN delays every later event by one cycle.
- Buffer full: count == DEPTH forces `wr_ready` = 0; further writes are dropped and `count` is unchanged.
- Reset mid-stream: immediate return to the reset values; buffered data is discarded.
- Back-to-back: a write or `start` is accepted in the `done` cycle (IDLE).

## Test plan
- Reset: hold `rst_n` = 0 with random inputs. Expect all outputs at reset values, `wr_ready` = 1. Deassert `rst_n`, then a write is accepted.
- Basic skew: write {04,03,02,01} then {14,13,12,11} (row3..row0), `start` at T, `sa_ready` = 1. Expect:
  - row0 = 01 at T+2 and 11 at T+3.
  - row3 = 04 at T+5 and 14 at T+6.
  - `a_valid` = 0001, 0011, 0111, 1111, 1110, 1100, 1000 across T+2…T+8 is wrong for N=2; the correct sequence is 0001, 0011, 0110, 1100, 1000 over T+2…T+6.
  - `done` at T+7.
- Full buffer: issue 17 writes with values 0…16. Expect `wr_ready` = 0 after the 16th; the stream carries exactly values 0…15, with `done` at T+21.
- Back-pressure: N = 4, drive `sa_ready` = 0 for 3 cycles starting at T+4. Expect outputs frozen for those cycles, slice order intact, `done` at T+12 instead of T+9.
- Start corner cases:
  - `start` with count = 0 is ignored; `busy` stays 0.
  - `start` together with the first write streams N = 1: row r valid only at T+2+r, `done` at T+6.
- Reset mid-stream: assert `rst_n` = 0 at T+4 of an N = 8 stream. Expect outputs cleared immediately, count = 0, no `done` pulse. A new load of 1 vector then streams correctly.
